regfile_wr_arbiter: RTL and testbench

- Owns the single write port of the register file; the register file's `wr_en`/`wr_addr`/`wr_data` are driven only from this block.
- After reset, sequences a zero-initialisation sweep of every register.
- Then shares the write port between NUM_REQ requesters using round-robin arbitration with a valid/ready handshake.
- Drives registered write outputs, so the register file sees clean, glitch-free write controls.

---
 rtl/regfile_wr_arbiter.sv | 135 +++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wr_arbiter
// Purpose  : Sole owner of the register-file write port. After reset it
//            sweeps zeros into every register. It then shares the port
//            between NUM_REQ requesters using round-robin arbitration with a
//            valid/ready handshake. All write controls come from registers.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            req_valid/addr/data   - packed per-requester write requests
//            req_ready             - one-hot accept (combinational)
//            wr_en/wr_addr/wr_data - registered register-file write port
//            grant_id              - requester owning the current wr_* write
//            init_done             - set once the zero sweep has finished
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wr_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH_ADDR   = 5,
    parameter int WIDTH_DATA   = 32,
    parameter int PROTECT_ZERO = 1
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [NUM_REQ-1:0]                             req_valid,
    input  logic [NUM_REQ*WIDTH_ADDR-1:0]                  req_addr,
    input  logic [NUM_REQ*WIDTH_DATA-1:0]                  req_data,
    output logic [NUM_REQ-1:0]                             req_ready,
    output logic                                           wr_en,
    output logic [WIDTH_ADDR-1:0]                          wr_addr,
    output logic [WIDTH_DATA-1:0]                          wr_data,
    output logic [(NUM_REQ > 1 ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
    output logic                                           init_done
);

    localparam int c_GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [0:0] c_ST_INIT = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [0:0]            r_state;
    logic [WIDTH_ADDR-1:0] r_init_cnt;
    logic [c_GW-1:0]       r_rr_ptr;
    logic                  r_wr_en;
    logic [WIDTH_ADDR-1:0] r_wr_addr;
    logic [WIDTH_DATA-1:0] r_wr_data;
    logic [c_GW-1:0]       r_grant_id;
    logic                  r_init_done;

    logic                  w_any;
    logic [c_GW-1:0]       w_idx;
    logic [c_GW-1:0]       w_grant;
    logic [c_GW-1:0]       w_next_ptr;
    logic [NUM_REQ-1:0]    w_onehot;
    logic [WIDTH_ADDR-1:0] w_grant_addr;
    logic [WIDTH_DATA-1:0] w_grant_data;
    logic                  w_drop_zero;

    assign w_any = |req_valid;

    // Scan from the farthest position back toward rr_ptr, so the last hit
    // (the one nearest rr_ptr) wins the grant.
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = c_GW'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (req_valid[w_idx]) begin
                w_grant = w_idx;
            end
        end
    end

    always_comb begin
        w_onehot          = '0;
        w_onehot[w_grant] = 1'b1;
    end

    assign w_next_ptr   = (w_grant == c_GW'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
    assign w_grant_addr = req_addr[int'(w_grant)*WIDTH_ADDR +: WIDTH_ADDR];
    assign w_grant_data = req_data[int'(w_grant)*WIDTH_DATA +: WIDTH_DATA];

    // When address 0 is protected, the write is accepted (ready pulses) but
    // never reaches the register file.
    assign w_drop_zero  = (PROTECT_ZERO != 0) && (w_grant_addr == '0);

    assign req_ready = ((r_state == c_ST_RUN) && w_any) ? w_onehot : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_INIT;
            r_init_cnt  <= '0;
            r_rr_ptr    <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_grant_id  <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                c_ST_INIT: begin
                    r_wr_en    <= 1'b1;
                    r_wr_addr  <= r_init_cnt;
                    r_wr_data  <= '0;
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == {WIDTH_ADDR{1'b1}}) begin
                        r_state     <= c_ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                c_ST_RUN: begin
                    if (w_any) begin
                        r_wr_en    <= ~w_drop_zero;
                        r_wr_addr  <= w_grant_addr;
                        r_wr_data  <= w_grant_data;
                        r_grant_id <= w_grant;
                        r_rr_ptr   <= w_next_ptr;
                    end else begin
                        r_wr_en <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_ST_INIT;
                end
            endcase
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign grant_id  = r_grant_id;
    assign init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wr_arbiter
// Purpose  : Self-checking bench for regfile_wr_arbiter (4 requesters,
//            5-bit address, 32-bit data). A second instance with address-0
//            protection disabled shares the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_arbiter;

    typedef struct {
        logic        en;
        logic        en_nz;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [1:0]  gid;
        logic        done;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [19:0]  req_addr;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [31:0]  wr_data;
    logic [1:0]   grant_id;
    logic         init_done;

    logic [3:0]   nz_req_ready;
    logic         nz_wr_en;
    logic [4:0]   nz_wr_addr;
    logic [31:0]  nz_wr_data;
    logic [1:0]   nz_grant_id;
    logic         nz_init_done;

    int n_pass;
    int n_total;

    exp_t        sb[$];
    logic        m_run;
    int          m_cnt;
    int          m_rr;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [1:0]  m_gid;
    logic        m_done;

    regfile_wr_arbiter #(
        .NUM_REQ(4), .WIDTH_ADDR(5), .WIDTH_DATA(32), .PROTECT_ZERO(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .grant_id(grant_id),
        .init_done(init_done)
    );

    regfile_wr_arbiter #(
        .NUM_REQ(4), .WIDTH_ADDR(5), .WIDTH_DATA(32), .PROTECT_ZERO(0)
    ) dut_nz (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(nz_req_ready), .wr_en(nz_wr_en),
        .wr_addr(nz_wr_addr), .wr_data(nz_wr_data), .grant_id(nz_grant_id),
        .init_done(nz_init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_run  = 1'b0;
        m_cnt  = 0;
        m_rr   = 0;
        m_addr = '0;
        m_data = '0;
        m_gid  = '0;
        m_done = 1'b0;
        sb.delete();
    endtask

    // One clock: predict at the falling edge, compare after the rising edge.
    task automatic step();
        exp_t       e;
        logic [3:0] exp_ready;
        logic [3:0] v;
        int         g;
        int         j;
        @(negedge clk);
        exp_ready = '0;
        v         = req_valid;
        if (!m_run) begin
            e.en    = 1'b1;
            e.en_nz = 1'b1;
            m_addr  = m_cnt[4:0];
            m_data  = '0;
            if (m_cnt == 31) begin
                m_run  = 1'b1;
                m_done = 1'b1;
            end
            m_cnt++;
        end else begin
            g = -1;
            for (int k = 0; k < 4; k++) begin
                j = (m_rr + k) % 4;
                if (g < 0 && v[j[1:0]]) g = j;
            end
            if (g >= 0) begin
                exp_ready[g[1:0]] = 1'b1;
                m_addr  = req_addr[g*5 +: 5];
                m_data  = req_data[g*32 +: 32];
                m_gid   = g[1:0];
                e.en    = (m_addr != 5'd0);
                e.en_nz = 1'b1;
                m_rr    = (g + 1) % 4;
            end else begin
                e.en    = 1'b0;
                e.en_nz = 1'b0;
            end
        end
        e.addr = m_addr;
        e.data = m_data;
        e.gid  = m_gid;
        e.done = m_done;
        n_total++;
        if (req_ready !== exp_ready) $display("FAIL req_ready: got %b want %b @%0t", req_ready, exp_ready, $time);
        else n_pass++;
        n_total++;
        if (nz_req_ready !== exp_ready) $display("FAIL nz_req_ready: got %b want %b @%0t", nz_req_ready, exp_ready, $time);
        else n_pass++;
        sb.push_back(e);
        @(posedge clk);
        #1;
        n_total++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard: got empty queue want one entry @%0t", $time);
        end else begin
            n_pass++;
            e = sb.pop_front();
            n_total++;
            if (wr_en !== e.en) $display("FAIL wr_en: got %b want %b @%0t", wr_en, e.en, $time);
            else n_pass++;
            n_total++;
            if (nz_wr_en !== e.en_nz) $display("FAIL nz_wr_en: got %b want %b @%0t", nz_wr_en, e.en_nz, $time);
            else n_pass++;
            n_total++;
            if (wr_addr !== e.addr || nz_wr_addr !== e.addr) $display("FAIL wr_addr: got %0d/%0d want %0d @%0t", wr_addr, nz_wr_addr, e.addr, $time);
            else n_pass++;
            n_total++;
            if (wr_data !== e.data || nz_wr_data !== e.data) $display("FAIL wr_data: got %h/%h want %h @%0t", wr_data, nz_wr_data, e.data, $time);
            else n_pass++;
            n_total++;
            if (grant_id !== e.gid || nz_grant_id !== e.gid) $display("FAIL grant_id: got %0d/%0d want %0d @%0t", grant_id, nz_grant_id, e.gid, $time);
            else n_pass++;
            n_total++;
            if (init_done !== e.done || nz_init_done !== e.done) $display("FAIL init_done: got %b/%b want %b @%0t", init_done, nz_init_done, e.done, $time);
            else n_pass++;
        end
    endtask

    // Async reset pulse issued just after a rising edge; outputs must clear
    // before the next edge arrives.
    task automatic async_reset_check(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'd0 || grant_id !== 2'd0 || init_done !== 1'b0)
            $display("FAIL %s: got en=%b addr=%0d data=%h gid=%0d done=%b want all zero", tag, wr_en, wr_addr, wr_data, grant_id, init_done);
        else n_pass++;
        n_total++;
        if (req_ready !== 4'b0000) $display("FAIL %s_ready: got %b want 0000", tag, req_ready);
        else n_pass++;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        model_reset();
        #12;
        n_total++;
        if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'd0 || grant_id !== 2'd0 || init_done !== 1'b0)
            $display("FAIL reset_state: got en=%b addr=%0d data=%h gid=%0d done=%b want all zero", wr_en, wr_addr, wr_data, grant_id, init_done);
        else n_pass++;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_init_sweep();
        for (int i = 0; i < 32; i++) step();
        n_total++;
        if (init_done !== 1'b1 || wr_addr !== 5'd31) $display("FAIL init_final: got done=%b addr=%0d want 1/31", init_done, wr_addr);
        else n_pass++;
        step();
        step();
        n_total++;
        if (wr_en !== 1'b0) $display("FAIL idle_after_init: got wr_en=%b want 0", wr_en);
        else n_pass++;
    endtask

    task automatic test_request_during_init();
        rst_n = 1'b0;
        req_valid = 4'b0001;
        req_addr[4:0]  = 5'd9;
        req_data[31:0] = 32'h0000_1234;
        #2;
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) step();
        step();
        n_total++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd9 || wr_data !== 32'h1234 || grant_id !== 2'd0)
            $display("FAIL first_run_grant: got en=%b addr=%0d data=%h gid=%0d want 1/9/1234/0", wr_en, wr_addr, wr_data, grant_id);
        else n_pass++;
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_round_robin();
        int exp_g[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) begin
            req_addr[i*5 +: 5]   = 5'(i + 1);
            req_data[i*32 +: 32] = 32'(10 + i);
        end
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step();
            n_total++;
            if (grant_id !== exp_g[i][1:0] || wr_addr !== 5'(exp_g[i] + 1)) $display("FAIL rr_order[%0d]: got gid=%0d addr=%0d want %0d", i, grant_id, wr_addr, exp_g[i]);
            else n_pass++;
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_rr_pointer();
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0011;
        step();
        n_total++;
        if (grant_id !== 2'd0) $display("FAIL ptr2_first: got %0d want 0", grant_id);
        else n_pass++;
        req_valid = 4'b0010;
        step();
        n_total++;
        if (grant_id !== 2'd1) $display("FAIL ptr2_second: got %0d want 1", grant_id);
        else n_pass++;
        req_valid = 4'b1000;
        step();
        n_total++;
        if (grant_id !== 2'd3) $display("FAIL grant3: got %0d want 3", grant_id);
        else n_pass++;
        req_valid = 4'b1111;
        step();
        n_total++;
        if (grant_id !== 2'd0) $display("FAIL ptr_wrap: got %0d want 0", grant_id);
        else n_pass++;
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_protect_zero();
        req_addr[9:5]   = 5'd0;
        req_data[63:32] = 32'hFFFF_FFFF;
        req_valid = 4'b0010;
        step();
        n_total++;
        if (wr_en !== 1'b0 || grant_id !== 2'd1) $display("FAIL protect_zero: got en=%b gid=%0d want 0/1", wr_en, grant_id);
        else n_pass++;
        n_total++;
        if (nz_wr_en !== 1'b1 || nz_wr_addr !== 5'd0 || nz_wr_data !== 32'hFFFF_FFFF)
            $display("FAIL unprotected_zero: got en=%b addr=%0d data=%h want 1/0/ffffffff", nz_wr_en, nz_wr_addr, nz_wr_data);
        else n_pass++;
        req_addr[4:0]  = 5'd7;
        req_data[31:0] = 32'h77;
        req_valid = 4'b0001;
        step();
        n_total++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd7) $display("FAIL after_protect: got en=%b addr=%0d want 1/7", wr_en, wr_addr);
        else n_pass++;
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_reset_midflight();
        async_reset_check("reset_pulse");
        for (int i = 0; i < 18; i++) step();
        n_total++;
        if (wr_addr !== 5'd17 || wr_en !== 1'b1) $display("FAIL mid_init_addr: got %0d want 17", wr_addr);
        else n_pass++;
        async_reset_check("reset_mid_init");
        step();
        n_total++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd0) $display("FAIL sweep_restart: got en=%b addr=%0d want 1/0", wr_en, wr_addr);
        else n_pass++;
        for (int i = 0; i < 31; i++) step();
        req_valid = 4'b1111;
        step();
        async_reset_check("reset_mid_run");
        req_valid = 4'b0000;
        step();
        n_total++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd0 || init_done !== 1'b0) $display("FAIL run_restart: got en=%b addr=%0d done=%b want 1/0/0", wr_en, wr_addr, init_done);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_init_sweep();
        test_request_during_init();
        test_round_robin();
        test_rr_pointer();
        test_protect_zero();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test want finish before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
